// File: rtl/hazard_scoreboard.sv
// Per-register scoreboard of in-flight writes. Drives operand forwarding selects,
// the decode hazard stall and a saturating stall counter.
module hazard_scoreboard #(
    parameter int NSRC = 2,
    parameter int AW   = 5,
    parameter int CNTW = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 D_VALID,
    input  logic [NSRC*AW-1:0]   D_ADDR,
    input  logic [NSRC-1:0]      D_USE,
    input  logic                 D_WEN,
    input  logic [AW-1:0]        D_WADDR,
    input  logic [1:0]           D_LAT,
    input  logic                 EXT_STALL,
    input  logic                 FLUSH,
    output logic [NSRC*2-1:0]    FWD_SEL,
    output logic                 STALL,
    output logic [(2**AW)-1:0]   BUSY,
    output logic [CNTW-1:0]      STALL_CNT
);

    localparam int NREGS = 2**AW;

    logic [NREGS-1:0] r_busy;
    logic [1:0]       r_age [NREGS];
    logic [1:0]       r_lat [NREGS];
    logic [CNTW-1:0]  r_stall_cnt;

    logic [AW-1:0]     w_src [NSRC];
    logic [NSRC*2-1:0] w_fwd_sel;
    logic [NSRC-1:0]   w_hazard;
    logic              w_stall;
    logic              w_issue;
    logic              w_alloc;
    logic [1:0]        w_new_lat;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        assign w_src[i] = D_ADDR[i*AW +: AW];
    end

    // A source hazards only while its youngest producer has not yet reached its result stage.
    always_comb begin
        w_fwd_sel = '0;
        w_hazard  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (D_USE[i] && (w_src[i] != '0) && r_busy[w_src[i]]) begin
                w_fwd_sel[i*2 +: 2] = r_age[w_src[i]];
                w_hazard[i]         = (r_age[w_src[i]] < r_lat[w_src[i]]);
            end
        end
    end

    assign w_stall   = D_VALID & ~FLUSH & (|w_hazard);
    assign w_issue   = D_VALID & ~w_stall & ~EXT_STALL & ~FLUSH;
    assign w_alloc   = w_issue & D_WEN & (D_WADDR != '0);
    assign w_new_lat = (D_LAT == 2'd0) ? 2'd1 : D_LAT;

    // Allocation takes priority over aging/retire of the same entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_busy <= '0;
            for (int r = 0; r < NREGS; r++) begin
                r_age[r] <= 2'd0;
                r_lat[r] <= 2'd0;
            end
        end else if (!EXT_STALL) begin
            for (int r = 0; r < NREGS; r++) begin
                if (w_alloc && (D_WADDR == AW'(r))) begin
                    r_busy[r] <= 1'b1;
                    r_age[r]  <= 2'd1;
                    r_lat[r]  <= w_new_lat;
                end else if (r_busy[r]) begin
                    if (r_age[r] == 2'd3) begin
                        r_busy[r] <= 1'b0;
                    end else begin
                        r_age[r] <= r_age[r] + 2'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !EXT_STALL && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNTW'(1);
        end
    end

    assign FWD_SEL   = w_fwd_sel;
    assign STALL     = w_stall;
    assign BUSY      = r_busy;
    assign STALL_CNT = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding ages, load-use stalls, youngest
// producer, freeze, x0, flush, issue-on-retire, counter saturation and reset.
module tb_hazard_scoreboard;

    localparam int NSRC = 2;
    localparam int AW   = 5;
    localparam int CNTW = 32;

    logic              CLK = 1'b0;
    logic              RST;
    logic              D_VALID;
    logic [NSRC*AW-1:0] D_ADDR;
    logic [NSRC-1:0]   D_USE;
    logic              D_WEN;
    logic [AW-1:0]     D_WADDR;
    logic [1:0]        D_LAT;
    logic              EXT_STALL;
    logic              FLUSH;
    logic [NSRC*2-1:0] FWD_SEL;
    logic              STALL;
    logic [31:0]       BUSY;
    logic [CNTW-1:0]   STALL_CNT;

    logic [NSRC*2-1:0] FWD_SEL_S;
    logic              STALL_S;
    logic [31:0]       BUSY_S;
    logic [1:0]        STALL_CNT_S;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    hazard_scoreboard #(.NSRC(NSRC), .AW(AW), .CNTW(CNTW)) dut (
        .CLK(CLK), .RST(RST), .D_VALID(D_VALID), .D_ADDR(D_ADDR), .D_USE(D_USE),
        .D_WEN(D_WEN), .D_WADDR(D_WADDR), .D_LAT(D_LAT), .EXT_STALL(EXT_STALL),
        .FLUSH(FLUSH), .FWD_SEL(FWD_SEL), .STALL(STALL), .BUSY(BUSY), .STALL_CNT(STALL_CNT)
    );

    // Narrow counter instance to exercise saturation.
    hazard_scoreboard #(.NSRC(NSRC), .AW(AW), .CNTW(2)) dut_s (
        .CLK(CLK), .RST(RST), .D_VALID(D_VALID), .D_ADDR(D_ADDR), .D_USE(D_USE),
        .D_WEN(D_WEN), .D_WADDR(D_WADDR), .D_LAT(D_LAT), .EXT_STALL(EXT_STALL),
        .FLUSH(FLUSH), .FWD_SEL(FWD_SEL_S), .STALL(STALL_S), .BUSY(BUSY_S), .STALL_CNT(STALL_CNT_S)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        D_VALID = 1'b0; D_WEN = 1'b0; D_USE = '0; D_ADDR = '0;
        FLUSH = 1'b0; EXT_STALL = 1'b0; D_LAT = 2'd1; D_WADDR = '0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic set_issue(input logic [4:0] rd, input logic [1:0] lat);
        D_VALID = 1'b1; D_WEN = 1'b1; D_WADDR = rd; D_LAT = lat; D_USE = '0; D_ADDR = '0;
    endtask

    task automatic set_read(input logic [4:0] a1, input logic [4:0] a0, input logic [1:0] use_v);
        D_VALID = 1'b1; D_WEN = 1'b0; D_ADDR = {a1, a0}; D_USE = use_v;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle(2);
        RST = 1'b0;
        set_read(5'd2, 5'd1, 2'b11);
        #1;
        checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", STALL); end
        checks++; if (FWD_SEL !== 4'b0000) begin errors++; $display("FAIL reset_fwd got %b exp 0000", FWD_SEL); end
        checks++; if (BUSY !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp 0", BUSY); end
        checks++; if (STALL_CNT !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", STALL_CNT); end
        idle(1);
    endtask

    task automatic test_alu_fwd();
        logic [1:0] exp_sel [4];
        exp_sel[0] = 2'b01; exp_sel[1] = 2'b10; exp_sel[2] = 2'b11; exp_sel[3] = 2'b00;
        set_issue(5'd5, 2'd1);
        tick();
        set_read(5'd0, 5'd5, 2'b01);
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (FWD_SEL[1:0] !== exp_sel[k]) begin errors++; $display("FAIL alu_fwd_age%0d got %b exp %b", k+1, FWD_SEL[1:0], exp_sel[k]); end
            checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL alu_stall%0d got %b exp 0", k+1, STALL); end
            tick();
        end
        idle(1);
    endtask

    task automatic test_load_use();
        set_issue(5'd7, 2'd2);
        tick();
        set_read(5'd7, 5'd0, 2'b10);
        #1;
        checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL load_use_stall got %b exp 1", STALL); end
        checks++; if (FWD_SEL[3:2] !== 2'b01) begin errors++; $display("FAIL load_use_fwd1 got %b exp 01", FWD_SEL[3:2]); end
        tick();
        checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL load_use_release got %b exp 0", STALL); end
        checks++; if (FWD_SEL[3:2] !== 2'b10) begin errors++; $display("FAIL load_use_fwd2 got %b exp 10", FWD_SEL[3:2]); end
        checks++; if (STALL_CNT !== 32'd1) begin errors++; $display("FAIL load_use_cnt got %0d exp 1", STALL_CNT); end
        idle(4);
    endtask

    task automatic test_youngest();
        set_issue(5'd3, 2'd1);
        tick();
        set_issue(5'd3, 2'd2);
        tick();
        set_read(5'd0, 5'd3, 2'b01);
        #1;
        checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL youngest_stall got %b exp 1", STALL); end
        checks++; if (FWD_SEL[1:0] !== 2'b01) begin errors++; $display("FAIL youngest_fwd got %b exp 01", FWD_SEL[1:0]); end
        tick();
        checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL youngest_release got %b exp 0", STALL); end
        checks++; if (FWD_SEL[1:0] !== 2'b10) begin errors++; $display("FAIL youngest_fwd2 got %b exp 10", FWD_SEL[1:0]); end
        checks++; if (STALL_CNT !== 32'd2) begin errors++; $display("FAIL youngest_cnt got %0d exp 2", STALL_CNT); end
        idle(4);
    endtask

    task automatic test_ext_stall();
        set_issue(5'd4, 2'd2);
        tick();
        set_read(5'd0, 5'd4, 2'b01);
        EXT_STALL = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL ext_stall_stall%0d got %b exp 1", k, STALL); end
            checks++; if (FWD_SEL[1:0] !== 2'b01) begin errors++; $display("FAIL ext_stall_age%0d got %b exp 01", k, FWD_SEL[1:0]); end
            checks++; if (STALL_CNT !== 32'd2) begin errors++; $display("FAIL ext_stall_cnt%0d got %0d exp 2", k, STALL_CNT); end
            tick();
        end
        EXT_STALL = 1'b0;
        #1;
        checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL ext_release_stall got %b exp 1", STALL); end
        tick();
        checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL ext_after_stall got %b exp 0", STALL); end
        checks++; if (FWD_SEL[1:0] !== 2'b10) begin errors++; $display("FAIL ext_after_fwd got %b exp 10", FWD_SEL[1:0]); end
        checks++; if (STALL_CNT !== 32'd3) begin errors++; $display("FAIL ext_after_cnt got %0d exp 3", STALL_CNT); end
        idle(4);
    endtask

    task automatic test_x0_and_flush();
        set_issue(5'd0, 2'd3);
        tick();
        checks++; if (BUSY[0] !== 1'b0) begin errors++; $display("FAIL x0_busy got %b exp 0", BUSY[0]); end
        set_read(5'd0, 5'd0, 2'b11);
        #1;
        checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL x0_stall got %b exp 0", STALL); end
        checks++; if (FWD_SEL !== 4'b0000) begin errors++; $display("FAIL x0_fwd got %b exp 0000", FWD_SEL); end
        set_issue(5'd6, 2'd2);
        tick();
        set_read(5'd0, 5'd6, 2'b01);
        D_WEN = 1'b1; D_WADDR = 5'd9; D_LAT = 2'd1; FLUSH = 1'b1;
        #1;
        checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL flush_stall got %b exp 0", STALL); end
        tick();
        checks++; if (BUSY[9] !== 1'b0) begin errors++; $display("FAIL flush_alloc got %b exp 0", BUSY[9]); end
        checks++; if (STALL_CNT !== 32'd3) begin errors++; $display("FAIL flush_cnt got %0d exp 3", STALL_CNT); end
        idle(4);
    endtask

    task automatic test_issue_on_retire();
        set_issue(5'd11, 2'd1);
        tick();
        idle(2);
        set_issue(5'd11, 2'd1);
        tick();
        set_read(5'd0, 5'd11, 2'b01);
        #1;
        checks++; if (BUSY[11] !== 1'b1) begin errors++; $display("FAIL retire_busy got %b exp 1", BUSY[11]); end
        checks++; if (FWD_SEL[1:0] !== 2'b01) begin errors++; $display("FAIL retire_fwd got %b exp 01", FWD_SEL[1:0]); end
        idle(4);
    endtask

    task automatic test_late_saturate();
        set_issue(5'd8, 2'd3);
        tick();
        set_read(5'd8, 5'd0, 2'b10);
        #1;
        checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL late_stall1 got %b exp 1", STALL); end
        tick();
        checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL late_stall2 got %b exp 1", STALL); end
        checks++; if (FWD_SEL[3:2] !== 2'b10) begin errors++; $display("FAIL late_fwd2 got %b exp 10", FWD_SEL[3:2]); end
        tick();
        checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL late_release got %b exp 0", STALL); end
        checks++; if (FWD_SEL[3:2] !== 2'b11) begin errors++; $display("FAIL late_fwd3 got %b exp 11", FWD_SEL[3:2]); end
        checks++; if (STALL_CNT !== 32'd5) begin errors++; $display("FAIL late_cnt got %0d exp 5", STALL_CNT); end
        checks++; if (STALL_CNT_S !== 2'd3) begin errors++; $display("FAIL sat_cnt got %0d exp 3", STALL_CNT_S); end
        idle(4);
    endtask

    task automatic test_mid_reset();
        set_issue(5'd10, 2'd1);
        tick();
        idle(0);
        EXT_STALL = 1'b1;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        EXT_STALL = 1'b0;
        checks++; if (BUSY !== 32'h0) begin errors++; $display("FAIL midrst_busy got %h exp 0", BUSY); end
        checks++; if (STALL_CNT !== 32'd0) begin errors++; $display("FAIL midrst_cnt got %0d exp 0", STALL_CNT); end
    endtask

    initial begin
        RST = 1'b1;
        D_VALID = 1'b0; D_ADDR = '0; D_USE = '0; D_WEN = 1'b0; D_WADDR = '0;
        D_LAT = 2'd1; EXT_STALL = 1'b0; FLUSH = 1'b0;
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_youngest();
        test_ext_stall();
        test_x0_and_flush();
        test_issue_on_retire();
        test_late_saturate();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
